// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM receive-side demultiplexer.
package tdm_pkg;

  localparam int unsigned CH_COUNT = 4;

  typedef logic [1:0] ch_sel_t;

  localparam ch_sel_t CH_A = 2'd0;
  localparam ch_sel_t CH_B = 2'd1;
  localparam ch_sel_t CH_C = 2'd2;
  localparam ch_sel_t CH_D = 2'd3;

endpackage

// File: rtl/tdm_demux_channel.sv
// One output channel of the demux: holding register, data-held flag and
// sticky overflow flag.
module demux_channel #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ack,
  input  logic             ovf_set,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             ovf
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;

    if (wr) begin
      data_d = wr_data;
    end

    // A write in the same cycle as an ack keeps the channel full.
    if (wr) begin
      valid_d = 1'b1;
    end else if (ack) begin
      valid_d = 1'b0;
    end

    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/tdm_demux.sv
// 1-to-4 demultiplexer: routes a time-multiplexed word stream into four
// registered channels, by explicit select or by a frame-aligned slot counter.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter bit DROP_ON_FULL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic [1:0]       in_sel,
  input  logic             enable,
  input  logic             auto_mode,
  input  logic             frame_sync,
  input  logic             clear_ovf,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ack,
  output logic [3:0]       overflow
);

  ch_sel_t slot_q, slot_d;
  ch_sel_t tgt;
  logic    accept;
  logic    beat;

  logic [CH_COUNT-1:0] wr_stb;
  logic [CH_COUNT-1:0] ovf_set;
  logic [CH_COUNT-1:0] valid;
  logic [CH_COUNT-1:0] ovf;
  logic [WIDTH-1:0]    ch_data [CH_COUNT];

  always_comb begin
    tgt = auto_mode ? (frame_sync ? CH_A : slot_q) : ch_sel_t'(in_sel);

    if (DROP_ON_FULL) begin
      in_ready = rst_n & enable & (~valid[tgt] | out_ack[tgt]);
    end else begin
      in_ready = rst_n & enable;
    end

    accept = in_valid & in_ready;
    beat   = enable & in_valid & auto_mode;

    wr_stb  = '0;
    ovf_set = '0;
    for (int unsigned i = 0; i < CH_COUNT; i++) begin
      wr_stb[i] = accept & (tgt == ch_sel_t'(i));
      if (DROP_ON_FULL) begin
        ovf_set[i] = enable & in_valid & ~in_ready & (tgt == ch_sel_t'(i));
      end else begin
        ovf_set[i] = wr_stb[i] & valid[i] & ~out_ack[i];
      end
    end

    // The slot advances on every beat, dropped or not, to keep frame alignment.
    slot_d = slot_q;
    if (frame_sync) begin
      slot_d = beat ? CH_B : CH_A;
    end else if (beat) begin
      slot_d = slot_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= CH_A;
    end else begin
      slot_q <= slot_d;
    end
  end

  for (genvar g = 0; g < CH_COUNT; g++) begin : g_ch
    demux_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr     (wr_stb[g]),
      .wr_data(in_data),
      .ack    (out_ack[g]),
      .ovf_set(ovf_set[g]),
      .ovf_clr(clear_ovf),
      .data   (ch_data[g]),
      .valid  (valid[g]),
      .ovf    (ovf[g])
    );
  end

  assign out_a     = ch_data[CH_A];
  assign out_b     = ch_data[CH_B];
  assign out_c     = ch_data[CH_C];
  assign out_d     = ch_data[CH_D];
  assign out_valid = valid;
  assign overflow  = ovf;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench: both overflow policies driven with the same stimulus
// and compared against a behavioural model of the channels and slot.
module tb_tdm_demux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       iv, en, auto, fs, clr;
  logic [1:0] sel;
  logic [3:0] ack;

  logic [1:0]            rdy;
  logic [1:0][3:0]       vld;
  logic [1:0][3:0]       ovf;
  logic [1:0][3:0][7:0]  od;

  int n_vec = 0;
  int n_err = 0;

  // Model state, index 0 = drop-on-full, index 1 = overwrite.
  logic [7:0] md [2][4];
  bit         mv [2][4];
  bit         mo [2][4];
  int         ms [2];

  always #5 clk = ~clk;

  tdm_demux #(.WIDTH(8), .DROP_ON_FULL(1'b1)) u_drop (
    .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(iv), .in_sel(sel),
    .enable(en), .auto_mode(auto), .frame_sync(fs), .clear_ovf(clr),
    .in_ready(rdy[0]), .out_a(od[0][0]), .out_b(od[0][1]), .out_c(od[0][2]),
    .out_d(od[0][3]), .out_valid(vld[0]), .out_ack(ack), .overflow(ovf[0])
  );

  tdm_demux #(.WIDTH(8), .DROP_ON_FULL(1'b0)) u_ovw (
    .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(iv), .in_sel(sel),
    .enable(en), .auto_mode(auto), .frame_sync(fs), .clear_ovf(clr),
    .in_ready(rdy[1]), .out_a(od[1][0]), .out_b(od[1][1]), .out_c(od[1][2]),
    .out_d(od[1][3]), .out_valid(vld[1]), .out_ack(ack), .overflow(ovf[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_tgt(input int m);
    if (auto) return fs ? 0 : ms[m];
    return int'(sel);
  endfunction

  function automatic bit m_rdy(input int m, input int t);
    return rst_n && en && (m == 1 || !mv[m][t] || ack[t]);
  endfunction

  task automatic m_reset();
    for (int m = 0; m < 2; m++) begin
      ms[m] = 0;
      for (int c = 0; c < 4; c++) begin
        md[m][c] = 8'h00;
        mv[m][c] = 1'b0;
        mo[m][c] = 1'b0;
      end
    end
  endtask

  task automatic m_update();
    int t;
    bit r, acc, wr, set, beat;
    if (!rst_n) begin
      m_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      t   = m_tgt(m);
      r   = m_rdy(m, t);
      acc = iv && r;
      for (int c = 0; c < 4; c++) begin
        wr  = acc && (t == c);
        set = (m == 0) ? (en && iv && !r && t == c) : (wr && mv[m][c] && !ack[c]);
        mv[m][c] = wr ? 1'b1 : (ack[c] ? 1'b0 : mv[m][c]);
        mo[m][c] = set ? 1'b1 : (clr ? 1'b0 : mo[m][c]);
        if (wr) md[m][c] = din;
      end
      beat = en && iv && auto;
      if (fs) ms[m] = beat ? 1 : 0;
      else if (beat) ms[m] = (ms[m] + 1) % 4;
    end
  endtask

  task automatic compare();
    logic [3:0] ev, eo;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d_in_ready", m), rdy[m], m_rdy(m, m_tgt(m)));
      for (int c = 0; c < 4; c++) begin
        check($sformatf("m%0d_out%0d", m, c), od[m][c], md[m][c]);
        ev[c] = mv[m][c];
        eo[c] = mo[m][c];
      end
      check($sformatf("m%0d_out_valid", m), vld[m], ev);
      check($sformatf("m%0d_overflow", m), ovf[m], eo);
    end
  endtask

  // Entered and left at posedge+1; inputs must already be set.
  task automatic step();
    #2;
    compare();
    m_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iv = 1'b0; fs = 1'b0; clr = 1'b0; ack = 4'h0; en = 1'b1;
  endtask

  initial begin
    idle();
    auto = 1'b0; sel = 2'd0; din = 8'h00;
    rst_n = 1'b0;
    m_reset();
    #6;
    step();
    step();
    rst_n = 1'b1;

    // Manual routing
    for (int i = 0; i < 4; i++) begin
      idle(); iv = 1'b1; sel = 2'(i); din = 8'(8'h11 * (i + 1));
      step();
    end
    check("man_a", od[0][0], 8'h11);
    check("man_b", od[0][1], 8'h22);
    check("man_c", od[0][2], 8'h33);
    check("man_d", od[0][3], 8'h44);
    check("man_valid", vld[0], 4'b1111);
    check("man_ovf", ovf[1], 4'b0000);

    // Full channel A: drop vs overwrite
    idle(); iv = 1'b1; sel = 2'd0; din = 8'h55;
    #1;
    check("drop_ready", rdy[0], 1'b0);
    check("ovw_ready", rdy[1], 1'b1);
    step();
    check("drop_keep", od[0][0], 8'h11);
    check("drop_ovf", ovf[0][0], 1'b1);
    check("ovw_data", od[1][0], 8'h55);
    check("ovw_ovf", ovf[1][0], 1'b1);

    // Same-cycle ack frees the channel
    idle(); iv = 1'b1; sel = 2'd0; din = 8'h5A; ack = 4'b0001;
    #1;
    check("ack_ready", rdy[0], 1'b1);
    step();
    check("ack_data", od[0][0], 8'h5A);
    check("ack_valid", vld[0][0], 1'b1);

    idle(); clr = 1'b1;
    step();
    check("clr_ovf0", ovf[0], 4'b0000);
    check("clr_ovf1", ovf[1], 4'b0000);

    // Auto mode with wrap
    idle(); ack = 4'hF;
    step();
    idle(); auto = 1'b1; fs = 1'b1; iv = 1'b1; din = 8'hA0;
    step();
    for (int k = 1; k <= 4; k++) begin
      idle(); iv = 1'b1; din = 8'(8'hA0 + k);
      step();
    end
    check("auto_a", od[0][0], 8'hA0);
    check("auto_b", od[0][1], 8'hA1);
    check("auto_c", od[0][2], 8'hA2);
    check("auto_d", od[0][3], 8'hA3);
    check("auto_wrap_ovf", ovf[0], 4'b0001);
    check("auto_wrap_ovw", od[1][0], 8'hA4);

    // Enable gating
    idle(); en = 1'b0; iv = 1'b1; din = 8'h77; ack = 4'b0010;
    #1;
    check("gate_ready", rdy[0], 1'b0);
    step();
    check("gate_ack", vld[0], 4'b1101);
    check("gate_hold_ovf", ovf[0], 4'b0001);
    idle(); iv = 1'b1; din = 8'h78;
    step();
    check("gate_slot_b", od[0][1], 8'h78);

    // Reset mid-stream
    idle(); ack = 4'hF; clr = 1'b1;
    step();
    idle(); auto = 1'b0; iv = 1'b1; sel = 2'd2; din = 8'hC2;
    step();
    idle(); auto = 1'b1; fs = 1'b1; iv = 1'b1; din = 8'hB0;
    step();
    idle(); iv = 1'b1; din = 8'hB1;
    step();
    check("pre_rst_valid", vld[0], 4'b0111);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", vld[0], 4'b0000);
    check("rst_out_a", od[0][0], 8'h00);
    check("rst_out_c", od[1][2], 8'h00);
    check("rst_ready", rdy[0], 1'b0);
    m_reset();
    step();
    rst_n = 1'b1;
    idle(); iv = 1'b1; din = 8'hE1;
    step();
    check("post_rst_valid", vld[0], 4'b0001);
    check("post_rst_a", od[0][0], 8'hE1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      en   = ($urandom % 8) != 0;
      iv   = ($urandom % 4) != 0;
      sel  = 2'($urandom);
      din  = 8'($urandom);
      fs   = ($urandom % 9) == 0;
      clr  = ($urandom % 13) == 0;
      ack  = 4'($urandom & $urandom);
      if (n % 50 == 0) auto = 1'($urandom);
      step();
    end

    idle();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Synchronous 1-to-4 demultiplexer: the receive-side counterpart of the four-input 8-bit select mux.
- Takes a single time-multiplexed byte stream and routes each word into one of four registered output channels (A..D).
- Each channel has its own valid/ack handshake and a sticky overflow flag.
- Routing comes from an explicit select or from an internal slot counter aligned by a frame-sync pulse.

Parameters:
- WIDTH, 8, data width of the input word and each output channel.
- DROP_ON_FULL, 1, 1 = a word for a full channel is refused; 0 = the new word overwrites the held word.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  multiplexed input word.
- in_valid  input  1  in_data is valid this cycle.
- in_sel  input  2  target channel when auto_mode=0 (00=A, 01=B, 10=C, 11=D).
- enable  input  1  block enable; 0 freezes routing.
- auto_mode  input  1  1 = target comes from the internal slot counter; in_sel is ignored.
- frame_sync  input  1  forces the slot counter to channel A.
- clear_ovf  input  1  clears all overflow flags.
- in_ready  output  1  the word is accepted this cycle if in_valid=1.
- out_a, out_b, out_c, out_d  output  WIDTH each  channel holding registers.
- out_valid  output  4  per-channel data-held flag; bit0=A ... bit3=D.
- out_ack  input  4  per-channel consumer acknowledge; clears out_valid.
- overflow  output  4  per-channel sticky overflow flag.

Behaviour:
- Reset (async, rst_n=0):
  - out_a..out_d = 0, out_valid = 0, overflow = 0, slot = 0.
  - in_ready = 0 while in reset.
- Target selection: tgt = auto_mode ? slot : in_sel. The slot value used is the one after frame_sync override.
  - If frame_sync=1, tgt = 0 in that cycle (auto mode).
- in_ready, combinational:
  - DROP_ON_FULL=1: in_ready = enable & (~out_valid[tgt] | out_ack[tgt]). A same-cycle ack frees the channel.
  - DROP_ON_FULL=0: in_ready = enable.
- accept = in_valid & in_ready.
  - On accept, out_<tgt> <= in_data and out_valid[tgt] <= 1.
  - Data and valid are visible the cycle after acceptance (latency 1).
- Per-channel valid update:
  - ack without accept to that channel clears out_valid.
  - ack and accept in the same cycle leaves valid=1 with the new data.
  - ack on a non-valid channel has no effect.
- Overflow (per channel, sticky):
  - DROP_ON_FULL=1: set when enable & in_valid & ~in_ready for tgt. The word is dropped and the held data is unchanged.
  - DROP_ON_FULL=0: set when accept to tgt while out_valid[tgt]=1 and out_ack[tgt]=0 (overwrite of unacknowledged data).
  - clear_ovf=1 clears all bits. If a set and clear_ovf occur in the same cycle, the set wins.
- Slot counter (2 bits):
  - Advances on every beat with enable & in_valid & auto_mode, whether accepted or dropped, so frame alignment is preserved.
  - Wraps 3 -> 0.
  - frame_sync=1 with no beat: slot <= 0.
  - frame_sync=1 with a beat: word goes to A and slot <= 1.
  - With auto_mode=0 the slot holds its value; frame_sync still resets it to 0.
- enable=0:
  - in_ready=0; no writes, no overflow sets, slot holds (frame_sync still honoured).
  - Outputs hold their last values; out_ack and clear_ovf are still processed.
- Reset asserted mid-stream: all state clears immediately; the first post-reset accepted word in auto mode goes to A.
- Output registers are never cleared by ack; only out_valid qualifies the data.

Decomposition:
- Shared package tdm_pkg:
  - CH_COUNT = 4.
  - typedef ch_sel_t (2-bit channel index).
  - Channel index constants CH_A..CH_D = 0..3.
- Sub-module demux_channel, instantiated four times. Each instance holds:
  - the holding register;
  - the valid flag with its wr/ack update;
  - the overflow flag with its set/clear rule.
- The top level contains only tgt/slot logic, in_ready generation and the decode to per-channel write strobes.

Test Plan:
- Manual routing: auto_mode=0, enable=1; send 0x11/0x22/0x33/0x44 with in_sel=0..3 -> next cycle out_a..d = 0x11..0x44, out_valid=4'b1111, overflow=0.
- Drop on full: DROP_ON_FULL=1; A holds 0x11 unacked; send 0x55 to A -> in_ready=0, out_a stays 0x11, overflow[0]=1. Same send with out_ack[0]=1 -> accepted, out_a=0x55, out_valid[0]=1.
- Overwrite policy: DROP_ON_FULL=0; A holds 0x11; send 0x66 to A -> out_a=0x66, overflow[0]=1. Then clear_ovf=1 -> overflow=0.
- Auto mode with wrap: auto_mode=1; frame_sync with word 0xA0, then 0xA1..0xA4 -> A=0xA0, B=0xA1, C=0xA2, D=0xA3, and 0xA4 goes to A (dropped with overflow[0]=1 if A is unacked).
- Enable gating: enable=0 with in_valid=1 and data 0x77 -> in_ready=0, no output or slot change, no overflow. Meanwhile out_ack[1]=1 clears out_valid[1].
- Reset mid-stream: assert rst_n=0 asynchronously with slot=2 and out_valid=4'b0111 -> outputs 0 immediately. After release, the next auto-mode word goes to A.
